uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4: number of byte-stream requesters, 2..8.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1024: stall cycles before a grant is revoked, at least 2.
REQ-003 The block SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1: reset, synchronous, active-low.
REQ-005 The block SHALL have port req_valid, input, N_REQ: per-requester byte valid.
REQ-006 The block SHALL have port req_data, input, 8*N_REQ: requester i byte on bits [8i+7:8i].
REQ-007 The block SHALL have port req_last, input, N_REQ: the current byte is the last byte of its frame.
REQ-008 The block SHALL have port req_ready, output, N_REQ: per-requester byte accepted.
REQ-009 The block SHALL have port tx_data, output, 8: byte to the UART TX FIFO.
REQ-010 The block SHALL have port tx_valid, output, 1: tx_data valid.
REQ-011 The block SHALL have port tx_ready, input, 1: UART TX FIFO not full.
REQ-012 The block SHALL have port grant, output, N_REQ: one-hot owner of the UART, or zero.
REQ-013 The block SHALL have port busy, output, 1: a frame is in progress.
REQ-014 The block SHALL have port timeout_evt, output, 1: one-cycle pulse when a grant is revoked.

Function
REQ-015 The block SHALL have exactly two states, IDLE and XFER, with busy = (state == XFER).
REQ-016 IDLE: grant, req_ready and tx_valid SHALL be 0, and tx_data SHALL be 0.
REQ-017 IDLE: if any req_valid is 1, the block SHALL select the first set bit searching round-robin from (ptr+1) mod N_REQ upward, register that requester as grant, and enter XFER on the next edge (1-cycle arbitration latency).
REQ-018 XFER, owner g: tx_valid = req_valid[g], tx_data = req_data[g], and req_ready[g] = tx_ready, all combinational with zero latency; all other req_ready bits SHALL be 0.
REQ-019 A byte SHALL transfer in a cycle where tx_valid and tx_ready are both 1; exactly one byte per such cycle, with no duplication or drop.
REQ-020 A transfer with req_last[g] = 1 SHALL set ptr to g, clear grant, and return the block to IDLE on the next edge.
REQ-021 The minimum gap between frames SHALL be 1 IDLE cycle, including when the same requester re-requests immediately.
REQ-022 req_valid[g] deasserting mid-frame SHALL NOT release the grant; bubbles are allowed.
REQ-023 Requests from non-owners SHALL be ignored until IDLE; no preemption.
REQ-024 req_last on a non-owner, or on a non-transfer cycle, SHALL have no effect.
REQ-025 The owner's tx_data and tx_valid SHALL pass through unchanged while tx_ready is 0 (backpressure).
REQ-026 Fairness: with all requesters continuously requesting, grants SHALL rotate 0,1,...,N_REQ-1,0,...

Reset
REQ-027 While reset_n = 0 at a clock edge, the block SHALL enter IDLE with grant = 0, busy = 0, timeout_evt = 0, stall counter = 0 and ptr = N_REQ-1, so that requester 0 wins first.
REQ-028 On reset mid-frame, the block SHALL abandon the frame without emitting further bytes; req_ready and tx_valid SHALL be 0 from the cycle after the reset edge.
REQ-029 The block SHALL ignore requests during reset; arbitration resumes on the first edge with reset_n = 1.

Configuration
REQ-030 With macro UART_ARB_TIMEOUT_EN defined, a stall counter SHALL clear on each transfer and on entering XFER, and otherwise increment each XFER cycle.
REQ-031 With the macro defined, when the counter reaches TIMEOUT_CYCLES-1 without a transfer, the block SHALL set ptr to g, return to IDLE next edge, and pulse timeout_evt high for exactly that one cycle.
REQ-032 With the macro defined, if a req_last transfer occurs in the same cycle as the terminal count, the transfer SHALL win: normal release, and timeout_evt SHALL stay 0.
REQ-033 Without the macro, the block SHALL have no counter and timeout_evt SHALL be tied to 0; a stalled owner holds the grant indefinitely.

Verification
REQ-034 Scenario: after reset, req_valid = 4'b1111, every byte has last = 1, tx_ready = 1 -> grant sequence 0001, 0010, 0100, 1000, 0001, with one IDLE cycle between grants.
REQ-035 Scenario: requester 2 sends 3 bytes 0x7B, 0x68, 0x7D (last on 0x7D) with tx_ready toggling 1,0,1,0,1 -> tx stream is exactly 0x7B, 0x68, 0x7D, and req_ready[2] mirrors tx_ready.
REQ-036 Scenario: requester 1 is granted while requester 3 requests, frame of 5 bytes -> requester 3 is granted only after requester 1's last byte plus 1 cycle, with no interleaved bytes.
REQ-037 Scenario: with UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, the owner sends 1 byte (no last) then req_valid = 0 -> timeout_evt high for 1 cycle, 8 cycles after that transfer, then IDLE.
REQ-038 Scenario: reset_n = 0 for 1 cycle in the middle of a 4-byte frame from requester 0 -> tx_valid = 0 and grant = 0 next cycle; after release, a new request from requester 1 is granted first if requester 0 is idle.
REQ-039 Scenario: with UART_ARB_TIMEOUT_EN, a last-byte transfer exactly at the terminal count -> normal release and timeout_evt = 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter granting one byte-stream requester at a time to a UART TX FIFO.
// Optional stall timeout is enabled with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [N_REQ-1:0]     grant,
    output logic                 busy,
    output logic                 timeout_evt
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] XFER = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;

    logic [PTR_W-1:0] pick;
    logic             pick_found;
    logic             own_valid;
    logic             own_last;
    logic [7:0]       own_data;
    logic             fire;
    logic             frame_end;
    logic             stall_out;

    // Owner's signals are muxed with constant indices to keep widths exact.
    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == PTR_W'(i)) begin
                own_valid = req_valid[i];
                own_last  = req_last[i];
                own_data  = req_data[i*8 +: 8];
            end
        end
    end

    // First requester found walking upward from the one after the last owner.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!pick_found && req_valid[i] && (((int'(ptr_q) + k) % N_REQ) == i)) begin
                    pick       = PTR_W'(i);
                    pick_found = 1'b1;
                end
            end
        end
    end

    assign busy      = (state_q == XFER);
    assign tx_valid  = busy && own_valid;
    assign tx_data   = busy ? own_data : 8'h00;
    assign fire      = tx_valid && tx_ready;
    assign frame_end = fire && own_last;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            grant[i]     = busy && (owner_q == PTR_W'(i));
            req_ready[i] = busy && (owner_q == PTR_W'(i)) && tx_ready;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A transfer in the terminal cycle takes priority over the timeout.
    assign stall_out = busy && !fire && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = '0;
        if (busy && !fire) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_cfg;

    assign stall_out  = 1'b0;
    assign unused_cfg = (TIMEOUT_CYCLES < 2);
`endif

    assign timeout_evt = stall_out;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = XFER;
                    owner_d = pick;
                end
            end
            XFER: begin
                if (frame_end || stall_out) begin
                    state_d = IDLE;
                    ptr_d   = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ptr resets to the last requester so requester 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= PTR_W'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic against a
// frame-level reference model and a byte scoreboard.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TC = 8;

    logic           clk;
    logic           rn;
    logic [N-1:0]   rv;
    logic [8*N-1:0] rd;
    logic [N-1:0]   rl;
    logic           tr;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic [N-1:0]   grant;
    logic           busy;
    logic           timeout_evt;

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TC)) dut (
        .clk        (clk),
        .reset_n    (rn),
        .req_valid  (rv),
        .req_data   (rd),
        .req_last   (rl),
        .req_ready  (req_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tr),
        .grant      (grant),
        .busy       (busy),
        .timeout_evt(timeout_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state: owner index (-1 = no frame), last owner, stall count.
    int m_owner = -1;
    int m_ptr   = N - 1;
    int m_stall = 0;

    logic [7:0]   exp_q[$];
    logic [7:0]   stream_q[$];
    logic [N-1:0] obs_grant;
    logic         obs_busy;
    logic         obs_txv;
    logic         obs_to;
    logic         m_fired;
    int           m_fire_owner;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: check outputs at the falling edge, then advance the model.
    task automatic tick();
        logic [N-1:0] e_grant;
        logic [N-1:0] e_ready;
        logic         e_busy;
        logic         e_txv;
        logic         e_to;
        logic         e_fire;
        logic [7:0]   e_data;
        logic [7:0]   popped;
        bit           chosen;
        int           c;
        @(negedge clk);
        e_busy  = (m_owner >= 0);
        e_grant = '0;
        e_ready = '0;
        e_txv   = 1'b0;
        e_data  = 8'h00;
        e_to    = 1'b0;
        e_fire  = 1'b0;
        if (e_busy) begin
            e_grant[m_owner] = 1'b1;
            e_ready[m_owner] = tr;
            e_txv            = rv[m_owner];
            e_data           = rd[8*m_owner +: 8];
            e_fire           = e_txv && tr;
`ifdef UART_ARB_TIMEOUT_EN
            e_to = !e_fire && (m_stall == TC - 1);
`endif
        end
        check_eq("busy", busy, e_busy);
        check_eq("grant", grant, e_grant);
        check_eq("req_ready", req_ready, e_ready);
        check_eq("tx_valid", tx_valid, e_txv);
        check_eq("tx_data", tx_data, e_data);
        check_eq("timeout_evt", timeout_evt, e_to);

        if (e_fire) exp_q.push_back(e_data);
        if (tx_valid && tr) begin
            check_eq("sb_depth", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                popped = exp_q.pop_front();
                check_eq("sb_byte", tx_data, popped);
            end
            stream_q.push_back(tx_data);
        end
        obs_grant    = grant;
        obs_busy     = busy;
        obs_txv      = tx_valid;
        obs_to       = timeout_evt;
        m_fired      = e_fire;
        m_fire_owner = m_owner;

        if (!rn) begin
            m_owner = -1;
            m_ptr   = N - 1;
            m_stall = 0;
        end else if (m_owner < 0) begin
            chosen = 1'b0;
            for (int k = 1; k <= N; k++) begin
                c = (m_ptr + k) % N;
                if (!chosen && rv[c]) begin
                    chosen  = 1'b1;
                    m_owner = c;
                    m_stall = 0;
                end
            end
        end else if (e_fire && rl[m_owner]) begin
            m_ptr   = m_owner;
            m_owner = -1;
        end else if (e_fire) begin
            m_stall = 0;
        end else if (e_to) begin
            m_ptr   = m_owner;
            m_owner = -1;
        end else begin
            m_stall++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rn = 1'b0;
        rv = '0;
        rl = '0;
        tr = 1'b1;
        tick();
        rn = 1'b1;
    endtask

    logic [N-1:0] gseq[$];
    logic [N-1:0] rr_exp[5];
    logic [7:0]   s2_bytes[3];
    logic         s2_ready[5];
    logic [N-1:0] prev_g;
    int           b;
    int           t_last;
    int           t_grant3;
    int           at_k;
    int           pulses;
    int           vpct;

    initial begin
        rn = 1'b0;
        rv = '0;
        rd = '0;
        rl = '0;
        tr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rn = 1'b1;

        // Reset state
        tick();
        check_eq("reset_idle_busy", obs_busy, 1'b0);

        // Fairness: everyone requesting single-byte frames
        do_reset();
        rv = '1;
        rl = '1;
        tr = 1'b1;
        prev_g = '0;
        gseq.delete();
        for (int c = 0; c < 12; c++) begin
            rd = $urandom;
            tick();
            if (obs_grant != '0 && prev_g == '0) gseq.push_back(obs_grant);
            prev_g = obs_grant;
        end
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        check_eq("rr_count", gseq.size(), 6);
        for (int i = 0; i < 5; i++) begin
            if (i < gseq.size()) check_eq("rr_seq", gseq[i], rr_exp[i]);
        end

        // Requester 2 under toggling backpressure
        do_reset();
        s2_bytes = '{8'h7B, 8'h68, 8'h7D};
        s2_ready = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        rv = 4'b0100;
        rl = '0;
        tr = 1'b0;
        rd = $urandom;
        rd[23:16] = s2_bytes[0];
        tick();
        stream_q.delete();
        b = 0;
        for (int t = 0; t < 5; t++) begin
            tr = s2_ready[t];
            rv = (b < 3) ? 4'b0100 : 4'b0000;
            rd = $urandom;
            rd[23:16] = s2_bytes[(b < 3) ? b : 2];
            rl[2] = (b == 2);
            tick();
            if (m_fired) b++;
        end
        rv = '0;
        rl = '0;
        tick();
        check_eq("bp_count", stream_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < stream_q.size()) check_eq("bp_byte", stream_q[i], s2_bytes[i]);
        end
        check_eq("bp_released", obs_busy, 1'b0);

        // Requester 3 waits for requester 1's 5-byte frame
        do_reset();
        tr = 1'b1;
        rl = 4'b1000;
        rv = 4'b0010;
        tick();
        rv = 4'b1010;
        stream_q.delete();
        b = 0;
        t_last = -1;
        t_grant3 = -1;
        for (int t = 0; t < 12; t++) begin
            rd = '0;
            rd[15:8]  = 8'h10 + 8'(b);
            rd[31:24] = 8'hA0;
            rl[1] = (b == 4);
            tick();
            if (m_fired && m_fire_owner == 1) begin
                if (b == 4) t_last = t;
                b++;
                if (b == 5) rv[1] = 1'b0;
            end
            if (m_fired && m_fire_owner == 3) rv[3] = 1'b0;
            if (obs_grant == 4'b1000 && t_grant3 < 0) t_grant3 = t;
        end
        check_eq("np_gap", t_grant3 - t_last, 2);
        check_eq("np_count", stream_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < stream_q.size()) check_eq("np_byte", stream_q[i], (i < 5) ? 8'h10 + 8'(i) : 8'hA0);
        end

        // Reset in the middle of a frame from requester 0
        do_reset();
        rv = 4'b0001;
        rl = '0;
        tr = 1'b1;
        for (int t = 0; t < 3; t++) begin
            rd = $urandom;
            tick();
        end
        rn = 1'b0;
        tick();
        rn = 1'b1;
        rv = 4'b0010;
        tick();
        check_eq("mid_rst_txv", obs_txv, 1'b0);
        check_eq("mid_rst_grant", obs_grant, 4'b0000);
        rl = 4'b0010;
        tick();
        check_eq("post_rst_grant", obs_grant, 4'b0010);
        rv = '0;
        rl = '0;
        tick();

`ifdef UART_ARB_TIMEOUT_EN
        // Owner stalls after one byte
        do_reset();
        rv = 4'b0001;
        rl = '0;
        tr = 1'b1;
        tick();
        tick();
        rv = '0;
        at_k = 0;
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (obs_to) begin
                pulses++;
                if (at_k == 0) at_k = k;
            end
        end
        check_eq("to_delay", at_k, 8);
        check_eq("to_pulses", pulses, 1);
        check_eq("to_idle", obs_busy, 1'b0);

        // Last byte exactly at the terminal count
        do_reset();
        rv = 4'b0001;
        rl = '0;
        tick();
        tick();
        rv = '0;
        repeat (7) tick();
        rv = 4'b0001;
        rl = 4'b0001;
        tick();
        check_eq("tc_last_no_to", obs_to, 1'b0);
        check_eq("tc_last_fire", m_fired, 1'b1);
        rv = '0;
        rl = '0;
        tick();
        check_eq("tc_last_idle", obs_busy, 1'b0);
`else
        // Stalled owner keeps the grant indefinitely
        do_reset();
        rv = 4'b0001;
        rl = '0;
        tr = 1'b1;
        tick();
        tick();
        rv = '0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (obs_to) pulses++;
        end
        check_eq("hold_pulses", pulses, 0);
        check_eq("hold_busy", obs_busy, 1'b1);
        rv = 4'b0001;
        rl = 4'b0001;
        tick();
        rv = '0;
        rl = '0;
        tick();
`endif

        // Randomized traffic
        do_reset();
        vpct = 4;
        for (int c = 0; c < 3000; c++) begin
            if (c % 300 == 0) vpct = $urandom_range(1, 7);
            rn = ($urandom_range(0, 299) != 0);
            for (int i = 0; i < N; i++) begin
                rv[i] = ($urandom_range(0, 7) < vpct);
                rl[i] = ($urandom_range(0, 3) == 0);
            end
            rd = $urandom;
            tr = ($urandom_range(0, 3) != 0);
            tick();
        end
        rn = 1'b1;
        rv = '0;
        tick();

        check_eq("sb_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
